// File: rtl/exp_golomb_bitstream_writer.sv
// Exp-Golomb ue(v)/se(v) encoder packing codewords MSB-first into 16-bit words.
// Define RBSP_TRAILING_EN to append a '1' stop bit before the flush zero fill.
module exp_golomb_bitstream_writer (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_flush,
  input  logic        in_is_se,
  input  logic [15:0] in_value,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_word,
  output logic        out_last,
  output logic        flush_done
);

  typedef enum logic {RUN, FLUSH} state_t;

  state_t      state;
  logic        s1_valid;
  logic        s1_flush;
  logic [31:0] s1_code;
  logic [5:0]  s1_len;
  logic [47:0] bit_buf;
  logic [5:0]  cnt;
  logic        done_q;

  logic [15:0] neg;
  logic [15:0] code_num;
  logic [15:0] cn1;
  logic [3:0]  m;
  logic [5:0]  code_len;
  logic [31:0] code_al;

  always_comb begin
    neg      = 16'd0 - in_value;
    code_num = in_value;
    if (in_is_se) begin
      if (!in_value[15] && in_value != 16'd0)
        code_num = {in_value[14:0], 1'b0} - 16'd1;
      else if (in_value == 16'h8000)
        code_num = 16'hFFFE;
      else
        code_num = {neg[14:0], 1'b0};
    end else if (in_value == 16'hFFFF) begin
      code_num = 16'hFFFE;
    end
    cn1 = code_num + 16'd1;
    m   = 4'd0;
    for (int i = 1; i < 16; i++)
      if (cn1[i]) m = 4'(i);
    code_len = {1'b0, m, 1'b0} + 6'd1;
    code_al  = {16'h0000, cn1} << (6'd32 - code_len);
  end

  logic run;
  logic pop;
  logic merge;
  logic accept;

  assign run       = (state == RUN);
  assign out_valid = !reset &&
                     (run ? (cnt >= 6'd16) : (cnt != 6'd0));
  assign out_word  = reset ? 16'h0000 : bit_buf[47:32];
  assign out_last  = !reset && !run && (cnt == 6'd16);
  assign flush_done = done_q && !reset;

  assign pop    = out_valid && out_ready;
  assign merge  = run && s1_valid && (cnt <= 6'd16);
  assign in_ready = run && !reset && (!s1_valid || merge);
  assign accept = in_valid && in_ready;

  logic [47:0] buf_p;
  logic [5:0]  cnt_p;
  logic [47:0] buf_m;
  logic [5:0]  cnt_m;
  logic [47:0] buf_f;
  logic [5:0]  cnt_t;
  logic [5:0]  cnt_pad;

  // Merge lands at the post-pop count so a pop and a merge can share a cycle.
  always_comb begin
    buf_p = pop ? (bit_buf << 16) : bit_buf;
    cnt_p = pop ? (cnt - 6'd16) : cnt;
    buf_m = buf_p | ({s1_code, 16'h0000} >> cnt_p);
    cnt_m = cnt_p + s1_len;
`ifdef RBSP_TRAILING_EN
    buf_f = buf_m | (48'h8000_0000_0000 >> cnt_m);
    cnt_t = cnt_m + 6'd1;
`else
    buf_f = buf_m;
    cnt_t = cnt_m;
`endif
    cnt_pad = (cnt_t + 6'd15) & 6'h30;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= RUN;
      bit_buf  <= '0;
      cnt      <= '0;
      s1_valid <= 1'b0;
      s1_flush <= 1'b0;
      s1_code  <= '0;
      s1_len   <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (accept) begin
        s1_valid <= 1'b1;
        s1_flush <= in_flush;
        s1_code  <= in_flush ? 32'h0 : code_al;
        s1_len   <= in_flush ? 6'd0 : code_len;
      end else if (merge) begin
        s1_valid <= 1'b0;
      end
      case (state)
        RUN: begin
          if (merge && s1_flush) begin
            bit_buf <= buf_f;
            cnt     <= cnt_pad;
            if (cnt_pad == 6'd0) done_q <= 1'b1;
            else                 state  <= FLUSH;
          end else if (merge) begin
            bit_buf <= buf_m;
            cnt     <= cnt_m;
          end else if (pop) begin
            bit_buf <= buf_p;
            cnt     <= cnt_p;
          end
        end
        FLUSH: begin
          if (pop) begin
            bit_buf <= buf_p;
            cnt     <= cnt_p;
            if (cnt == 6'd16) begin
              state  <= RUN;
              done_q <= 1'b1;
            end
          end
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_exp_golomb_bitstream_writer.sv
// Directed bench for exp_golomb_bitstream_writer.
// Expected words are hand-computed; the stress case uses a bit-level model.
module tb_exp_golomb_bitstream_writer;

`ifdef RBSP_TRAILING_EN
  localparam bit TR = 1'b1;
`else
  localparam bit TR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic        in_flush;
  logic        in_is_se;
  logic [15:0] in_value;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_word;
  logic        out_last;
  logic        flush_done;

  exp_golomb_bitstream_writer dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_flush   (in_flush),
    .in_is_se   (in_is_se),
    .in_value   (in_value),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_word   (out_word),
    .out_last   (out_last),
    .flush_done (flush_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [16:0] wq[$];
  bit          bq[$];
  int          fd_n = 0;
  int          fd_cyc = 0;
  int          pop_cyc = 0;
  int          acc_cyc = 0;
  bit          fd_rdy = 1'b0;
  bit          ov_seen = 1'b0;
  bit          stall_seen = 1'b0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      wq.push_back({out_last, out_word});
      pop_cyc = cyc;
    end
    if (out_valid) ov_seen = 1'b1;
    if (flush_done) begin
      fd_n++;
      fd_cyc = cyc;
      fd_rdy = in_ready;
    end
    if (in_valid && !in_ready && !reset) stall_seen = 1'b1;
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic send(input logic fl, input logic se,
                      input logic [15:0] v);
    int t;
    t = 0;
    in_valid = 1'b1;
    in_flush = fl;
    in_is_se = se;
    in_value = v;
    @(negedge clk);
    while (!in_ready && t < 500) begin
      t++;
      @(negedge clk);
    end
    if (!in_ready) chk("accept_timeout", in_ready, 1);
    acc_cyc = cyc;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_flush = 1'b0;
  endtask

  task automatic wait_fd(input int n0);
    int t;
    t = 0;
    while (fd_n == n0 && t < 2000) begin
      t++;
      @(negedge clk);
    end
    if (fd_n == n0) chk("flush_timeout", fd_n, n0 + 1);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic model_code(input bit se, input logic [15:0] v);
    int k;
    int cn;
    int mm;
    if (se) begin
      k = int'($signed(v));
      if (k == -32768) k = -32767;
      cn = (k > 0) ? 2 * k - 1 : -2 * k;
    end else begin
      cn = (v == 16'hFFFF) ? 65534 : int'(v);
    end
    mm = 0;
    while (((cn + 1) >> (mm + 1)) != 0) mm++;
    for (int i = 0; i < mm; i++) bq.push_back(1'b0);
    for (int i = mm; i >= 0; i--) bq.push_back(((cn + 1) >> i) & 1);
  endtask

  task automatic model_flush();
    if (TR) bq.push_back(1'b1);
    while (bq.size() % 16 != 0) bq.push_back(1'b0);
  endtask

  task automatic cmp_model(input string tag);
    int n;
    logic [15:0] w;
    n = bq.size() / 16;
    chk({tag, "_nwords"}, wq.size(), n);
    for (int i = 0; i < n && i < wq.size(); i++) begin
      for (int b = 0; b < 16; b++) w[15 - b] = bq[i * 16 + b];
      chk({tag, "_word"}, wq[i], {(i == n - 1), w});
    end
  endtask

  int n0;

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_flush  = 1'b0;
    in_is_se  = 1'b0;
    in_value  = 16'h0;
    out_ready = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_word", out_word, 16'h0000);
    chk("rst_out_last", out_last, 0);
    chk("rst_flush_done", flush_done, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    #1;

    // ue 0..3 then flush
    wq.delete();
    n0 = fd_n;
    send(0, 0, 16'd0);
    send(0, 0, 16'd1);
    send(0, 0, 16'd2);
    send(0, 0, 16'd3);
    send(1, 0, 16'd0);
    wait_fd(n0);
    chk("ue03_nwords", wq.size(), 1);
    if (wq.size() > 0)
      chk("ue03_word", wq[0], {1'b1, TR ? 16'hA648 : 16'hA640});
    chk("ue03_fd_timing", fd_cyc, pop_cyc + 1);
    chk("ue03_fd_count", fd_n, n0 + 1);

    // se +1, -1, 0, -32768 then flush
    wq.delete();
    n0 = fd_n;
    send(0, 1, 16'd1);
    send(0, 1, 16'hFFFF);
    send(0, 1, 16'd0);
    send(0, 1, 16'h8000);
    send(1, 0, 16'd0);
    wait_fd(n0);
    chk("se_nwords", wq.size(), 3);
    if (wq.size() > 2) begin
      chk("se_w0", wq[0], {1'b0, 16'h4E00});
      chk("se_w1", wq[1], {1'b0, 16'h03FF});
      chk("se_w2", wq[2], {1'b1, TR ? 16'hFE00 : 16'hFC00});
    end

    // ue 65534 then flush
    wq.delete();
    n0 = fd_n;
    send(0, 0, 16'd65534);
    send(1, 0, 16'd0);
    wait_fd(n0);
    chk("ue_max_nwords", wq.size(), 2);
    if (wq.size() > 1) begin
      chk("ue_max_w0", wq[0], {1'b0, 16'h0001});
      chk("ue_max_w1", wq[1], {1'b1, TR ? 16'hFFFF : 16'hFFFE});
    end

    // ue 65535 clamps to 65534
    wq.delete();
    n0 = fd_n;
    send(0, 0, 16'hFFFF);
    send(1, 0, 16'd0);
    wait_fd(n0);
    chk("ue_clamp_nwords", wq.size(), 2);
    if (wq.size() > 1) begin
      chk("ue_clamp_w0", wq[0], {1'b0, 16'h0001});
      chk("ue_clamp_w1", wq[1], {1'b1, TR ? 16'hFFFF : 16'hFFFE});
    end

    // se +32767 -> codeNum 65533
    wq.delete();
    n0 = fd_n;
    send(0, 1, 16'd32767);
    send(1, 0, 16'd0);
    wait_fd(n0);
    chk("se_max_nwords", wq.size(), 2);
    if (wq.size() > 1) begin
      chk("se_max_w0", wq[0], {1'b0, 16'h0001});
      chk("se_max_w1", wq[1], {1'b1, TR ? 16'hFFFD : 16'hFFFC});
    end

    // 40 x ue 65534 under backpressure
    wq.delete();
    bq.delete();
    n0 = fd_n;
    stall_seen = 1'b0;
    out_ready = 1'b0;
    begin
      bit done;
      done = 1'b0;
      fork
        begin
          for (int i = 0; i < 40; i++) begin
            send(0, 0, 16'd65534);
            model_code(0, 16'd65534);
          end
          done = 1'b1;
        end
        begin
          repeat (20) @(posedge clk);
          while (!done) begin
            #1 out_ready = 1'($urandom_range(0, 1));
            @(posedge clk);
          end
        end
      join
    end
    out_ready = 1'b1;
    send(1, 0, 16'd0);
    model_flush();
    wait_fd(n0);
    chk("bp_stall_seen", stall_seen, 1);
    cmp_model("bp");

    // mid-stream reset discards buffered bits
    wq.delete();
    send(0, 0, 16'd1);
    send(0, 0, 16'd1);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    n0 = fd_n;
    send(1, 0, 16'd0);
    wait_fd(n0);
    chk("rst_mid_nwords", wq.size(), TR ? 1 : 0);
    if (wq.size() > 0)
      chk("rst_mid_word", wq[0], {1'b1, 16'h8000});
    chk("rst_mid_fd", fd_n, n0 + 1);

    // flush on empty buffer
    wq.delete();
    ov_seen = 1'b0;
    n0 = fd_n;
    send(1, 0, 16'd0);
    begin
      int a;
      a = acc_cyc;
      wait_fd(n0);
`ifndef RBSP_TRAILING_EN
      chk("empty_fd_timing", fd_cyc, a + 2);
      chk("empty_no_valid", ov_seen, 0);
`else
      chk("empty_fd_after_accept", fd_cyc > a + 2, 1);
`endif
    end
    chk("empty_nwords", wq.size(), TR ? 1 : 0);
    chk("empty_ready_at_fd", fd_rdy, 1);

    // stream resumes after an empty flush
    wq.delete();
    n0 = fd_n;
    send(0, 0, 16'd0);
    send(1, 0, 16'd0);
    wait_fd(n0);
    chk("resume_nwords", wq.size(), 1);
    if (wq.size() > 0)
      chk("resume_word", wq[0], {1'b1, TR ? 16'hC000 : 16'h8000});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got %0d exp 0", cyc);
    $fatal(1, "timeout");
  end

endmodule
